// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register: two-entry skid buffer with valid/ready handshake,
// synchronous flush and a saturating backpressure-cycle counter.
module pipe_stage_skid #(
  parameter int DATA_W = 40,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;

    if (out_valid_q && !out_ready && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + CNT_W'(1);

    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain move is possible
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end

    // handshake outputs are registered so they never see out_ready/in_valid
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: queue-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_pipe_stage_skid;
  localparam int DATA_W = 40;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  bit check_en = 1'b0;

  logic [DATA_W-1:0] mq[$];
  int                mcnt = 0;
  logic [DATA_W-1:0] got[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // reference model: FIFO of depth 2 with registered ready/valid
  always @(posedge clk) begin
    bit ix, ox;
    if (reset) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (mq.size() > 0 && !out_ready && mcnt < CMAX) mcnt++;
      if (flush) mq.delete();
      else begin
        ox = (mq.size() > 0) && out_ready;
        ix = in_valid && (mq.size() < 2);
        if (ox) void'(mq.pop_front());
        if (ix) mq.push_back(in_data);
      end
    end
  end

  // deliveries as seen at the DUT boundary
  always @(posedge clk)
    if (!reset && out_valid === 1'b1 && out_ready) got.push_back(out_data);

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
      chk("m_out_data", 64'(out_data), mq.size() > 0 ? 64'(mq[0]) : 64'd0);
      chk("m_in_ready", {63'd0, in_ready}, {63'd0, mq.size() < 2});
      chk("m_stall_cnt", 64'(stall_cnt), 64'(mcnt));
    end
  end

  initial begin
    int ir_drop;
    int errs;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step();
    check_en = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    reset = 1'b0;

    // fill to TWO then reset mid-operation
    in_valid = 1'b1; in_data = 40'hA1; step();
    in_data = 40'hA2; step();
    in_valid = 1'b0;
    chk("two_ready", 64'(in_ready), 64'd0);
    chk("two_head", 64'(out_data), 64'hA1);
    chk("two_stall", 64'(stall_cnt), 64'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rstmid_valid", 64'(out_valid), 64'd0);
    chk("rstmid_data", 64'(out_data), 64'd0);
    chk("rstmid_ready", 64'(in_ready), 64'd1);
    chk("rstmid_stall", 64'(stall_cnt), 64'd0);

    // streaming at full rate
    got.delete(); ir_drop = 0; out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_valid = 1'b1; in_data = 40'(i);
      step();
      if (in_ready !== 1'b1) ir_drop++;
      if (i == 1) begin
        chk("stream_lat_valid", 64'(out_valid), 64'd1);
        chk("stream_lat_data", 64'(out_data), 64'd1);
      end
    end
    in_valid = 1'b0; step();
    chk("stream_ready", 64'(ir_drop), 64'd0);
    chk("stream_count", 64'(got.size()), 64'd100);
    errs = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== 40'(i + 1)) errs++;
    chk("stream_order", 64'(errs), 64'd0);

    // backpressure: third payload held off until TWO drains
    reset = 1'b1; step(); reset = 1'b0;
    got.delete(); out_ready = 1'b0;
    in_valid = 1'b1; in_data = 40'h11; step();
    in_data = 40'h22; step();
    in_data = 40'h33;
    chk("bp_ready_fall", 64'(in_ready), 64'd0);
    step(); step();
    chk("bp_ready_held", 64'(in_ready), 64'd0);
    out_ready = 1'b1; step();
    chk("bp_ready_recover", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0; step();
    chk("bp_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("bp_d0", 64'(got[0]), 64'h11);
      chk("bp_d1", 64'(got[1]), 64'h22);
      chk("bp_d2", 64'(got[2]), 64'h33);
    end
    chk("bp_stall", 64'(stall_cnt), 64'd3);

    // flush in TWO with an input offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 40'h44; step();
    in_data = 40'h45; step();
    flush = 1'b1; in_data = 40'h55; step();
    flush = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_data", 64'(out_data), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    chk("fl_stall", 64'(stall_cnt), 64'd5);
    got.delete();
    in_data = 40'h66; out_ready = 1'b1; step();
    in_valid = 1'b0; step();
    chk("fl_after_count", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("fl_after_data", 64'(got[0]), 64'h66);

    // reset and flush together
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 40'h77; step();
    in_data = 40'h78; step();
    reset = 1'b1; flush = 1'b1; in_data = 40'h79; step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rf_valid", 64'(out_valid), 64'd0);
    chk("rf_data", 64'(out_data), 64'd0);
    chk("rf_ready", 64'(in_ready), 64'd1);
    chk("rf_stall", 64'(stall_cnt), 64'd0);

    // counter saturation
    in_valid = 1'b1; in_data = 40'h99; step();
    in_valid = 1'b0;
    repeat (20) step();
    chk("sat_stall", 64'(stall_cnt), 64'd15);
    chk("sat_data", 64'(out_data), 64'h99);
    out_ready = 1'b1; step();
    chk("sat_drain_valid", 64'(out_valid), 64'd0);
    chk("sat_hold", 64'(stall_cnt), 64'd15);
    step();

    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
